// File: rtl/sparc_exu_regwb_pkg.sv
// Shared exu package: thread count, one-hot thread mask type and
// thread-index constants used by the register write-back slice.
package sparc_exu_regwb_pkg;

  localparam int NUM_THR = 4;

  typedef logic [NUM_THR-1:0] thr_mask_t;

  localparam thr_mask_t THR0 = 4'b0001;
  localparam thr_mask_t THR1 = 4'b0010;
  localparam thr_mask_t THR2 = 4'b0100;
  localparam thr_mask_t THR3 = 4'b1000;

endpackage

// File: rtl/sparc_exu_regwb_if.sv
// Write-back bus: E-stage write request, M/W kills, read bypass port,
// storage write outputs and per-thread pending flags.
interface sparc_exu_regwb_if
  import sparc_exu_regwb_pkg::*;
#(
  parameter int SIZE = 3
);

  thr_mask_t         thr_e;
  logic              wen_e;
  logic [SIZE-1:0]   data_e;
  logic              kill_m;
  logic              kill_w;
  thr_mask_t         thr_rd;
  logic [SIZE-1:0]   rd_data_in;
  logic              wen_w;
  thr_mask_t         thr_w;
  logic [SIZE-1:0]   data_in_w;
  logic [SIZE-1:0]   rd_data;
  thr_mask_t         pend;

  modport master (
    output thr_e, wen_e, data_e,
    output kill_m, kill_w,
    output thr_rd, rd_data_in,
    input  wen_w, thr_w, data_in_w,
    input  rd_data, pend
  );

  modport slave (
    input  thr_e, wen_e, data_e,
    input  kill_m, kill_w,
    input  thr_rd, rd_data_in,
    output wen_w, thr_w, data_in_w,
    output rd_data, pend
  );

endinterface

// File: rtl/sparc_exu_regwb_stg.sv
// One pipe stage: async-reset valid/thr/data flops.
// Ports: clk, arst_l, se, valid_d/thr_d/data_d in, valid_q/thr_q/data_q out.
module sparc_exu_regwb_stg
  import sparc_exu_regwb_pkg::*;
#(
  parameter int SIZE = 3
) (
  input  logic            clk,
  input  logic            arst_l,
  input  logic            se,
  input  logic            valid_d,
  input  thr_mask_t       thr_d,
  input  logic [SIZE-1:0] data_d,
  output logic            valid_q,
  output thr_mask_t       thr_q,
  output logic [SIZE-1:0] data_q
);

  // scan enable has no functional role in this model
  logic unused_se;
  assign unused_se = se;

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      valid_q <= 1'b0;
      thr_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      thr_q   <= thr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/sparc_exu_regwb.sv
// Two-stage (M, W) register write-back pipe with kills, pend flags and
// optional read bypass (macro EXU_REGWB_BYPASS_EN).
// Ports: clk, arst_l (async, active-low), se, io (slave bus).
module sparc_exu_regwb
  import sparc_exu_regwb_pkg::*;
#(
  parameter int SIZE = 3
) (
  input logic             clk,
  input logic             arst_l,
  input logic             se,
  sparc_exu_regwb_if.slave io
);

  logic            m_valid;
  thr_mask_t       m_thr;
  logic [SIZE-1:0] m_data;
  logic            w_valid;
  thr_mask_t       w_thr;
  logic [SIZE-1:0] w_data;

  sparc_exu_regwb_stg #(.SIZE(SIZE)) u_m (
    .clk     (clk),
    .arst_l  (arst_l),
    .se      (se),
    .valid_d (io.wen_e & (|io.thr_e)),
    .thr_d   (io.thr_e),
    .data_d  (io.data_e),
    .valid_q (m_valid),
    .thr_q   (m_thr),
    .data_q  (m_data)
  );

  sparc_exu_regwb_stg #(.SIZE(SIZE)) u_w (
    .clk     (clk),
    .arst_l  (arst_l),
    .se      (se),
    .valid_d (m_valid & ~io.kill_m),
    .thr_d   (m_thr),
    .data_d  (m_data),
    .valid_q (w_valid),
    .thr_q   (w_thr),
    .data_q  (w_data)
  );

  assign io.wen_w     = w_valid & ~io.kill_w;
  assign io.thr_w     = w_thr;
  assign io.data_in_w = w_data;
  assign io.pend      = ({NUM_THR{m_valid}} & m_thr)
                      | ({NUM_THR{w_valid}} & w_thr);

`ifdef EXU_REGWB_BYPASS_EN
  // younger M write shadows the older W write
  always_comb begin
    io.rd_data = io.rd_data_in;
    if (m_valid & ~io.kill_m & (m_thr == io.thr_rd))
      io.rd_data = m_data;
    else if (io.wen_w & (w_thr == io.thr_rd))
      io.rd_data = w_data;
  end
`else
  logic unused_rd;
  assign unused_rd  = ^io.thr_rd;
  assign io.rd_data = io.rd_data_in;
`endif

endmodule

// File: tb/tb_sparc_exu_regwb.sv
// Scoreboard bench for sparc_exu_regwb: history-based model of the
// write pipe, directed scenarios, random traffic, async reset.
module tb_sparc_exu_regwb;

  localparam int SIZE = 3;
  localparam int HN   = 4096;

  logic clk;
  logic arst_l;
  logic se;

  sparc_exu_regwb_if #(.SIZE(SIZE)) io ();

  sparc_exu_regwb #(.SIZE(SIZE)) dut (
    .clk    (clk),
    .arst_l (arst_l),
    .se     (se),
    .io     (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            wen;
    bit [3:0]      thr;
    bit [SIZE-1:0] data;
    bit [3:0]      pend;
    bit [SIZE-1:0] rd;
  } exp_t;

  exp_t q[$];

  // per-cycle record of what was offered at E and the kills seen
  bit            h_wen  [HN];
  bit [3:0]      h_thr  [HN];
  bit [SIZE-1:0] h_data [HN];
  bit            h_km   [HN];

  int n;
  int n_chk;
  int n_fail;

  always @(negedge clk) begin
    if (arst_l === 1'b1) begin
      assert ($onehot(io.thr_e))
        else $error("illegal thr_e %b", io.thr_e);
      assert ($onehot(io.thr_rd))
        else $error("illegal thr_rd %b", io.thr_rd);
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: compare DUT outputs against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (arst_l === 1'b1 && q.size() > 0) begin
      e = q.pop_front();
      chk("wen_w", int'(io.wen_w), int'(e.wen));
      chk("thr_w", int'(io.thr_w), int'(e.thr));
      chk("data_in_w", int'(io.data_in_w), int'(e.data));
      chk("pend", int'(io.pend), int'(e.pend));
      chk("rd_data", int'(io.rd_data), int'(e.rd));
    end
  end

  // drive one cycle at posedge+1, predict its outputs, advance
  task automatic step(bit wen, bit [3:0] thr, bit [SIZE-1:0] d,
                      bit km, bit kw, bit [3:0] rd,
                      bit [SIZE-1:0] rdin);
    exp_t e;
    bit lm, lw;
    io.wen_e      = wen;
    io.thr_e      = thr;
    io.data_e     = d;
    io.kill_m     = km;
    io.kill_w     = kw;
    io.thr_rd     = rd;
    io.rd_data_in = rdin;
    h_wen[n]  = wen;
    h_thr[n]  = thr;
    h_data[n] = d;
    h_km[n]   = km;
    // lm: last cycle's write now sits in M; lw: older write survived M
    lm = h_wen[n-1] && (h_thr[n-1] != 0);
    lw = h_wen[n-2] && (h_thr[n-2] != 0) && !h_km[n-1];
    e.wen  = lw && !kw;
    e.thr  = h_thr[n-2];
    e.data = h_data[n-2];
    e.pend = (lm ? h_thr[n-1] : 4'b0) | (lw ? h_thr[n-2] : 4'b0);
    e.rd   = rdin;
`ifdef EXU_REGWB_BYPASS_EN
    if (lm && !km && h_thr[n-1] == rd)
      e.rd = h_data[n-1];
    else if (e.wen && h_thr[n-2] == rd)
      e.rd = h_data[n-2];
`endif
    q.push_back(e);
    n++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int k, bit [3:0] rd, bit [SIZE-1:0] rdin);
    for (int i = 0; i < k; i++)
      step(1'b0, 4'b0001, '0, 1'b0, 1'b0, rd, rdin);
  endtask

  initial begin
    n      = 2;
    n_chk  = 0;
    n_fail = 0;
    se     = 1'b0;
    arst_l = 1'b0;
    io.wen_e      = 1'b0;
    io.thr_e      = 4'b0001;
    io.data_e     = '0;
    io.kill_m     = 1'b0;
    io.kill_w     = 1'b0;
    io.thr_rd     = 4'b0001;
    io.rd_data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst wen_w", int'(io.wen_w), 0);
    chk("rst thr_w", int'(io.thr_w), 0);
    chk("rst data_in_w", int'(io.data_in_w), 0);
    chk("rst pend", int'(io.pend), 0);
    arst_l = 1'b1;

    // single write, thread 0, data 5
    step(1'b1, 4'b0001, 3'd5, 1'b0, 1'b0, 4'b0001, 3'd2);
    idle(3, 4'b0001, 3'd2);
    // thread 1 write killed in M
    step(1'b1, 4'b0010, 3'd3, 1'b0, 1'b0, 4'b0010, 3'd4);
    step(1'b0, 4'b0001, 3'd0, 1'b1, 1'b0, 4'b0010, 3'd4);
    idle(3, 4'b0010, 3'd4);
    // write killed in W
    step(1'b1, 4'b1000, 3'd6, 1'b0, 1'b0, 4'b1000, 3'd1);
    step(1'b0, 4'b0001, 3'd0, 1'b0, 1'b0, 4'b1000, 3'd1);
    step(1'b0, 4'b0001, 3'd0, 1'b0, 1'b1, 4'b1000, 3'd1);
    idle(3, 4'b1000, 3'd1);
    // back-to-back thread 2 writes with bypass read of thread 2
    step(1'b1, 4'b0100, 3'd1, 1'b0, 1'b0, 4'b0100, 3'd0);
    step(1'b1, 4'b0100, 3'd7, 1'b0, 1'b0, 4'b0100, 3'd0);
    idle(4, 4'b0100, 3'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)),
           4'(1 << $urandom_range(0, 3)),
           SIZE'($urandom),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           4'(1 << $urandom_range(0, 3)),
           SIZE'($urandom));
    end

    // load M and W, then reset asynchronously mid-cycle
    step(1'b1, 4'b0001, 3'd3, 1'b0, 1'b0, 4'b0001, 3'd6);
    step(1'b1, 4'b0010, 3'd5, 1'b0, 1'b0, 4'b0001, 3'd6);
    io.wen_e = 1'b0;
    @(negedge clk);
    #2;
    chk("pre-rst pend", int'(io.pend), 3);
    arst_l = 1'b0;
    #1;
    chk("arst wen_w", int'(io.wen_w), 0);
    chk("arst thr_w", int'(io.thr_w), 0);
    chk("arst data_in_w", int'(io.data_in_w), 0);
    chk("arst pend", int'(io.pend), 0);
    chk("arst rd_data", int'(io.rd_data), 6);
    h_wen[n-1] = 1'b0; h_thr[n-1] = '0; h_data[n-1] = '0; h_km[n-1] = 1'b0;
    h_wen[n-2] = 1'b0; h_thr[n-2] = '0; h_data[n-2] = '0; h_km[n-2] = 1'b0;
    @(posedge clk);
    #1;
    arst_l = 1'b1;
    // first capture right after reset release
    step(1'b1, 4'b1000, 3'd7, 1'b0, 1'b0, 4'b1000, 3'd0);
    idle(4, 4'b1000, 3'd0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("queue drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
